// File: rtl/midi_writer.sv
// MIDI message serializer: status + up to two data bytes framed as 8N1 UART at BAUD_CYCLES clocks per bit.
// Optional running-status compression is enabled by defining MIDI_RUNNING_STATUS_EN.
module midi_writer #(
  parameter int BAUD_CYCLES = 3200
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] status_in,
  input  logic [3:0] channel_in,
  input  logic [7:0] data_byte1_in,
  input  logic [7:0] data_byte2_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_wire_out,
  output logic       done_out
);

  localparam int CW = (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BAUD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [3:0]      bit_q, bit_d;
  logic [2:0][7:0] msg_q, msg_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      last_q, last_d;
  logic            done_q, done_d;
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0]      rs_q, rs_d;
`endif

  logic       accept;
  logic       cyc_end;
  logic [7:0] status_byte;
  logic [7:0] cur_byte;
  logic       unused_bits;

  assign accept      = valid_in && (state_q == IDLE);
  assign cyc_end     = (cyc_q == CYC_LAST);
  assign status_byte = {status_in, channel_in};
  // MSBs of data bytes are forced low on the wire, so they are never read.
  assign unused_bits = ^{data_byte1_in[7], data_byte2_in[7]};

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    msg_d   = msg_q;
    sel_d   = sel_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
    rs_d    = rs_q;
`endif

    case (state_q)
      IDLE: begin
        // Types below 0x8 are accepted but dropped: the FSM simply stays in IDLE.
        if (accept && status_in[3]) begin
          msg_d[0] = status_byte;
          msg_d[1] = {1'b0, data_byte1_in[6:0]};
          msg_d[2] = {1'b0, data_byte2_in[6:0]};
          if (status_in == 4'hF)
            last_d = 2'd0;
          else if (status_in == 4'hC || status_in == 4'hD)
            last_d = 2'd1;
          else
            last_d = 2'd2;
          sel_d   = 2'd0;
          cyc_d   = '0;
          bit_d   = 4'd0;
          state_d = START;
`ifdef MIDI_RUNNING_STATUS_EN
          if (status_in == 4'hF) begin
            rs_d = 8'h00;
          end else begin
            if (status_byte == rs_q)
              sel_d = 2'd1;
            rs_d = status_byte;
          end
`endif
        end
      end

      START: begin
        if (cyc_end) begin
          cyc_d   = '0;
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      DATA: begin
        if (cyc_end) begin
          cyc_d = '0;
          if (bit_q == 4'd7) begin
            bit_d   = 4'd0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      STOP: begin
        if (cyc_end) begin
          cyc_d = '0;
          if (sel_q == last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            sel_d   = sel_q + 2'd1;
            state_d = START;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= 4'd0;
      msg_q   <= '0;
      sel_q   <= 2'd0;
      last_q  <= 2'd0;
      done_q  <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
      rs_q    <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      msg_q   <= msg_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef MIDI_RUNNING_STATUS_EN
      rs_q    <= rs_d;
`endif
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    cur_byte = msg_q[0];
      2'd1:    cur_byte = msg_q[1];
      default: cur_byte = msg_q[2];
    endcase
  end

  always_comb begin
    tx_wire_out = 1'b1;
    case (state_q)
      START:   tx_wire_out = 1'b0;
      DATA:    tx_wire_out = cur_byte[bit_q[2:0]];
      default: tx_wire_out = 1'b1;
    endcase
  end

  assign ready_out = (state_q == IDLE);
  assign done_out  = done_q;

endmodule

// File: tb/tb_midi_writer.sv
// Directed bench for midi_writer at BAUD_CYCLES=4: checks framing, byte counts, timing, drop, reset abort and running status.
module tb_midi_writer;

  localparam int BAUD  = 4;
  localparam int FRAME = 10 * BAUD;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [3:0] status_in = 4'h0;
  logic [3:0] channel_in = 4'h0;
  logic [7:0] data_byte1_in = 8'h00;
  logic [7:0] data_byte2_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       tx_wire_out;
  logic       done_out;

  midi_writer #(.BAUD_CYCLES(BAUD)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .status_in     (status_in),
    .channel_in    (channel_in),
    .data_byte1_in (data_byte1_in),
    .data_byte2_in (data_byte2_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .tx_wire_out   (tx_wire_out),
    .done_out      (done_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_bytes [3];
  int         exp_n;
  logic [7:0] rx_bytes [3];
  int         line_err, ready_err, done_cnt, done_cyc;

  // Issues one message and records the line cycle by cycle against the expected framed bytes.
  task automatic send_msg(input logic [3:0] st, input logic [3:0] ch,
                          input logic [7:0] b1, input logic [7:0] b2, input bit garble);
    int   cap_len;
    int   b;
    int   fb;
    logic e;
    cap_len   = exp_n * FRAME + 4;
    line_err  = 0;
    ready_err = 0;
    done_cnt  = 0;
    done_cyc  = 0;
    for (int i = 0; i < 3; i++) rx_bytes[i] = 8'hxx;
    @(negedge clk_in);
    status_in     = st;
    channel_in    = ch;
    data_byte1_in = b1;
    data_byte2_in = b2;
    valid_in      = 1'b1;
    @(posedge clk_in);
    for (int c = 1; c <= cap_len; c++) begin
      @(negedge clk_in);
      if (garble && c < exp_n * FRAME) begin
        status_in     = 4'h8;
        channel_in    = 4'hA;
        data_byte1_in = 8'h55;
        data_byte2_in = 8'h2A;
        valid_in      = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      if (c <= exp_n * FRAME) begin
        b  = (c - 1) / FRAME;
        fb = ((c - 1) % FRAME) / BAUD;
        if (fb == 0)
          e = 1'b0;
        else if (fb == 9)
          e = 1'b1;
        else
          e = exp_bytes[b][fb-1];
        if (fb >= 1 && fb <= 8 && ((c - 1) % BAUD) == BAUD / 2)
          rx_bytes[b][fb-1] = tx_wire_out;
      end else begin
        e = 1'b1;
      end
      if (tx_wire_out !== e) line_err++;
      if (ready_out !== (c > exp_n * FRAME)) ready_err++;
      if (done_out === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
    end
  endtask

  task automatic test_reset();
    rst_in    = 1'b1;
    valid_in  = 1'b1;
    status_in = 4'h9;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    n_checks++; if (tx_wire_out !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx_wire_out); end
    n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready_vs_valid: got %b required 1", ready_out); end
    n_checks++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done_out); end
    rst_in   = 1'b0;
    valid_in = 1'b0;
    @(negedge clk_in);
    n_checks++; if (tx_wire_out !== 1'b1) begin n_fail++; $display("FAIL reset_release_tx: got %b required 1", tx_wire_out); end
    $display("reset: tx=%b ready=%b done=%b", tx_wire_out, ready_out, done_out);
  endtask

  task automatic test_note_on();
    exp_n = 3; exp_bytes[0] = 8'h90; exp_bytes[1] = 8'h3C; exp_bytes[2] = 8'h64;
    send_msg(4'h9, 4'h0, 8'h3C, 8'h64, 1'b0);
    n_checks++; if (line_err !== 0) begin n_fail++; $display("FAIL note_on_line: %0d bad cycles, required 0", line_err); end
    n_checks++; if (ready_err !== 0) begin n_fail++; $display("FAIL note_on_ready: %0d bad cycles, required 0", ready_err); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL note_on_done_count: got %0d required 1", done_cnt); end
    n_checks++; if (done_cyc !== 121) begin n_fail++; $display("FAIL note_on_done_cycle: got %0d required 121", done_cyc); end
    $display("note_on: bytes %h %h %h done at cycle %0d", rx_bytes[0], rx_bytes[1], rx_bytes[2], done_cyc);
  endtask

  task automatic test_program_change();
    exp_n = 2; exp_bytes[0] = 8'hC5; exp_bytes[1] = 8'h12; exp_bytes[2] = 8'h00;
    send_msg(4'hC, 4'h5, 8'h12, 8'hAB, 1'b1);
    n_checks++; if (line_err !== 0) begin n_fail++; $display("FAIL prog_change_line: %0d bad cycles, required 0", line_err); end
    n_checks++; if (ready_err !== 0) begin n_fail++; $display("FAIL prog_change_ready: %0d bad cycles, required 0", ready_err); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL prog_change_done_count: got %0d required 1", done_cnt); end
    n_checks++; if (done_cyc !== 81) begin n_fail++; $display("FAIL prog_change_done_cycle: got %0d required 81", done_cyc); end
    $display("program_change: bytes %h %h done at cycle %0d", rx_bytes[0], rx_bytes[1], done_cyc);
  endtask

  task automatic test_data_mask();
    exp_n = 3; exp_bytes[0] = 8'hB2; exp_bytes[1] = 8'h7F; exp_bytes[2] = 8'h00;
    send_msg(4'hB, 4'h2, 8'hFF, 8'h80, 1'b0);
    n_checks++; if (line_err !== 0) begin n_fail++; $display("FAIL mask_line: %0d bad cycles, required 0", line_err); end
    n_checks++; if (rx_bytes[1] !== 8'h7F) begin n_fail++; $display("FAIL mask_byte1: got %h required 7f", rx_bytes[1]); end
    n_checks++; if (rx_bytes[2] !== 8'h00) begin n_fail++; $display("FAIL mask_byte2: got %h required 00", rx_bytes[2]); end
    n_checks++; if (done_cyc !== 121) begin n_fail++; $display("FAIL mask_done_cycle: got %0d required 121", done_cyc); end
    $display("data_mask: bytes %h %h %h", rx_bytes[0], rx_bytes[1], rx_bytes[2]);
  endtask

  task automatic test_drop();
    exp_n = 0;
    send_msg(4'h3, 4'h1, 8'h11, 8'h22, 1'b0);
    n_checks++; if (line_err !== 0) begin n_fail++; $display("FAIL drop_line: %0d low cycles, required 0", line_err); end
    n_checks++; if (ready_err !== 0) begin n_fail++; $display("FAIL drop_ready: %0d low cycles, required 0", ready_err); end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL drop_done: got %0d pulses required 0", done_cnt); end
    $display("drop: line errors %0d ready errors %0d done pulses %0d", line_err, ready_err, done_cnt);
  endtask

  task automatic test_reset_abort();
    int   dones;
    logic tx_before;
    @(negedge clk_in);
    status_in = 4'h9; channel_in = 4'h0; data_byte1_in = 8'h3C; data_byte2_in = 8'h64; valid_in = 1'b1;
    @(posedge clk_in);
    tx_before = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk_in);
      valid_in = 1'b0;
      if (c == 50) begin
        tx_before = tx_wire_out;
        rst_in    = 1'b1;
      end
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    n_checks++; if (tx_before !== 1'b0) begin n_fail++; $display("FAIL abort_pre_tx: got %b required 0", tx_before); end
    n_checks++; if (tx_wire_out !== 1'b1) begin n_fail++; $display("FAIL abort_tx: got %b required 1", tx_wire_out); end
    n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b required 1", ready_out); end
    dones = (done_out === 1'b1) ? 1 : 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_in);
      if (done_out === 1'b1) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses required 0", dones); end
    $display("reset_abort: tx before %b after %b ready %b done pulses %0d", tx_before, tx_wire_out, ready_out, dones);
  endtask

  task automatic test_back_to_back();
    exp_n = 3; exp_bytes[0] = 8'h90; exp_bytes[1] = 8'h3C; exp_bytes[2] = 8'h64;
    send_msg(4'h9, 4'h0, 8'h3C, 8'h64, 1'b0);
    n_checks++; if (done_cyc !== 121) begin n_fail++; $display("FAIL b2b_first_done_cycle: got %0d required 121", done_cyc); end
`ifdef MIDI_RUNNING_STATUS_EN
    exp_n = 2; exp_bytes[0] = 8'h40; exp_bytes[1] = 8'h7F; exp_bytes[2] = 8'h00;
`else
    exp_n = 3; exp_bytes[0] = 8'h90; exp_bytes[1] = 8'h40; exp_bytes[2] = 8'h7F;
`endif
    send_msg(4'h9, 4'h0, 8'h40, 8'h7F, 1'b0);
    n_checks++; if (line_err !== 0) begin n_fail++; $display("FAIL b2b_second_line: %0d bad cycles, required 0", line_err); end
    n_checks++; if (done_cyc !== exp_n * FRAME + 1) begin n_fail++; $display("FAIL b2b_second_done_cycle: got %0d required %0d", done_cyc, exp_n * FRAME + 1); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_second_done_count: got %0d required 1", done_cnt); end
    $display("back_to_back: second message %0d bytes, done at cycle %0d", exp_n, done_cyc);
  endtask

  task automatic test_system_msg();
    exp_n = 1; exp_bytes[0] = 8'hFE; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h00;
    send_msg(4'hF, 4'hE, 8'h55, 8'h66, 1'b0);
    n_checks++; if (line_err !== 0) begin n_fail++; $display("FAIL system_line: %0d bad cycles, required 0", line_err); end
    n_checks++; if (done_cyc !== 41) begin n_fail++; $display("FAIL system_done_cycle: got %0d required 41", done_cyc); end
    $display("system: byte %h done at cycle %0d", rx_bytes[0], done_cyc);
    exp_n = 3; exp_bytes[0] = 8'h90; exp_bytes[1] = 8'h3C; exp_bytes[2] = 8'h64;
    send_msg(4'h9, 4'h0, 8'h3C, 8'h64, 1'b0);
    n_checks++; if (line_err !== 0) begin n_fail++; $display("FAIL after_system_line: %0d bad cycles, required 0", line_err); end
    n_checks++; if (done_cyc !== 121) begin n_fail++; $display("FAIL after_system_done_cycle: got %0d required 121", done_cyc); end
    $display("after_system: bytes %h %h %h done at cycle %0d", rx_bytes[0], rx_bytes[1], rx_bytes[2], done_cyc);
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_program_change();
    test_data_mask();
    test_drop();
    test_reset_abort();
    test_back_to_back();
    test_system_msg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
